// File: rtl/rns_ohc_encoder.sv
// Binary-to-one-hot residue encoder with a 2-entry output buffer and a saturating error counter.
// Optional build macro RNS_OHC_WRAP_EN: out-of-range inputs encode (in_bin mod MODULUS) instead of all zeros.
module rns_ohc_encoder #(
    parameter int unsigned MODULUS = 9,
    parameter int unsigned IN_W    = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_bin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MODULUS-1:0] out_ohc,
    output logic               out_err,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   err_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t             state, state_nxt;
    logic               push, pop;
    logic [MODULUS-1:0] enc_ohc;
    logic               enc_err;
    logic [MODULUS-1:0] tail_ohc;
    logic               tail_err;
    int unsigned        sel;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // An out-of-range sel matches no bit, which yields the all-zero code.
    always_comb begin
        enc_err = (32'(in_bin) >= MODULUS);
`ifdef RNS_OHC_WRAP_EN
        sel = 32'(in_bin) % MODULUS;
`else
        sel = 32'(in_bin);
`endif
        enc_ohc = '0;
        for (int unsigned i = 0; i < MODULUS; i++) begin
            enc_ohc[i] = (sel == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop) begin
                    state_nxt = FULL;
                end else if (pop && !push) begin
                    state_nxt = EMPTY;
                end
            end
            FULL:    if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Head registers drive the outputs directly; tail only fills when the head is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ohc  <= '0;
            out_err  <= 1'b0;
            tail_ohc <= '0;
            tail_err <= 1'b0;
        end else if (state == EMPTY) begin
            if (push) begin
                out_ohc <= enc_ohc;
                out_err <= enc_err;
            end
        end else if (state == ONE) begin
            if (push && pop) begin
                out_ohc <= enc_ohc;
                out_err <= enc_err;
            end else if (push) begin
                tail_ohc <= enc_ohc;
                tail_err <= enc_err;
            end
        end else if (pop) begin
            out_ohc <= tail_ohc;
            out_err <= tail_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (push && enc_err) begin
            if (err_clr) begin
                err_cnt <= CNT_W'(1);
            end else if (err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_cnt <= '0;
        end
    end

endmodule

// File: doc/rns_ohc_encoder.md
# rns_ohc_encoder

Parametrised, pipelined binary-to-one-hot residue encoder for the RNS modulo-adder datapath. It accepts a binary residue for modulus `MODULUS` over a valid/ready handshake, registers its one-hot code into a 2-entry output buffer, and flags out-of-range inputs instead of producing X. It keeps a saturating count of rejected inputs. It feeds the one-hot modulo adders, one instance per RNS channel.

## Interface

**Parameters**
- `MODULUS`, default 9: channel modulus and one-hot width; ≥ 2.
- `IN_W`, default 4: binary input width; 2^IN_W ≥ MODULUS.
- `CNT_W`, default 8: error counter width.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input word present.
- `in_ready` out 1: encoder can accept a word.
- `in_bin` in IN_W: binary residue.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer accepts the head entry.
- `out_ohc` out MODULUS: one-hot residue. Bit i set means value i.
- `out_err` out 1: head entry came from an out-of-range input.
- `err_clr` in 1: synchronous clear of `err_cnt`.
- `err_cnt` out CNT_W: saturating count of out-of-range inputs accepted.

## Operation

- **Push:** `in_valid && in_ready` at a rising edge.
- **Pop:** `out_valid && out_ready` at a rising edge.
- **Encoding:**
  - `in_bin < MODULUS`: `out_ohc` = 1 << in_bin, `err` = 0.
  - `in_bin ≥ MODULUS`: `err` = 1; `out_ohc` is set by the Configuration section.
  - Encoding is computed at push time and stored with the entry.
- **Buffer:** 2-entry FIFO of {ohc, err}.
  - `count` ∈ {0, 1, 2}.
  - Head drives `out_ohc` and `out_err` directly from registers.
- **Buffer states:**
  - `EMPTY`: push → `ONE`.
  - `ONE`: push only → `FULL`; pop only → `EMPTY`; push and pop → `ONE` (head replaced by new word).
  - `FULL`: pop → `ONE`. No push is possible because `in_ready` = 0.
- **Handshake signals:**
  - `in_ready` = (count != 2), derived from registered state only; no combinational path from `out_ready`.
  - `out_valid` = (count != 0).
  - When `out_valid` = 0, `out_ohc` and `out_err` hold their last values.
- **Error counter:**
  - Increments by 1 on every push with err = 1; saturates at 2^CNT_W − 1.
  - `err_clr` alone: counter → 0.
  - `err_clr` with an erroring push in the same cycle: counter → 1.
- **Reset (asynchronous, any time, including mid-transfer):**
  - count → 0, `in_ready` → 1, `out_valid` → 0.
  - `out_ohc` → 0, `out_err` → 0, `err_cnt` → 0.
  - Buffered entries are discarded.
  - First push is possible at the first rising edge after `rst_n` is released.

## Timing

- Latency: a word pushed at edge k is visible with `out_valid` = 1 after edge k, i.e. in cycle k+1.
- Throughput: 1 word/cycle while `out_ready` = 1.
- Backpressure:
  - With `out_ready` held at 0, two words are absorbed; `in_ready` falls after the second push edge.
  - `in_ready` rises the cycle after the first pop.
- `err_cnt` updates at the push edge; the new value is visible the same cycle the entry appears at the output.
- All outputs are registered or decoded from registered count only.

## Configuration

- Macro: `RNS_OHC_WRAP_EN`.
- **Defined:** an out-of-range input produces `out_ohc` = 1 << (in_bin mod MODULUS), using constant-modulus reduction. `out_err` = 1 and `err_cnt` still increments.
- **Undefined:** an out-of-range input produces `out_ohc` = all zeros, with `out_err` = 1.
- In-range behaviour is identical in both builds.

## Test plan

All scenarios use MODULUS=9, IN_W=4 unless stated.

- **Full sweep:** push 0..8 with `out_ready` = 1 → one output per cycle, each 1 cycle after its push.
  - 0 gives 9'b000000001; 8 gives 9'b100000000.
  - `out_err` = 0 throughout; `err_cnt` = 0.
- **Out-of-range value:** push 12.
  - Without macro → `out_ohc` = 9'b000000000, `out_err` = 1, `err_cnt` = 1.
  - With `RNS_OHC_WRAP_EN` → `out_ohc` = 9'b000001000, `out_err` = 1.
- **Backpressure:** `out_ready` = 0, `in_valid` = 1 with words 1, 2, 3.
  - 1 and 2 are accepted; `in_ready` = 0 and 3 is held.
  - Raise `out_ready` → outputs appear in order 9'b000000010, 9'b000000100, 9'b000001000; no loss, no duplication.
- **Saturation (CNT_W=2):** push 15 five times → `err_cnt` sequence 1, 2, 3, 3, 3.
  - Then `err_clr` together with a push of 9 → `err_cnt` = 1.
- **Reset mid-operation:** buffer FULL with 2 entries; assert `rst_n` = 0 asynchronously between edges.
  - Immediately: `out_valid` = 0, `in_ready` = 1, `out_ohc` = 0, `err_cnt` = 0.
  - After release, push 5 → 9'b000100000 one cycle later.
- **Simultaneous push/pop in ONE state:** continuous stream 4, 7 with `out_ready` toggling 1, 0, 1 → count never exceeds 2; outputs appear in order 9'b000010000, 9'b010000000.
